bloom_table_writer: RTL and testbench

//  Builds and owns the censor Bloom table: accepts hash pairs from the hash

---
 rtl/bloom_table_writer.sv | 188 ++++++++++++++++++
 tb/tb_bloom_table_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_table_writer.sv
// -----------------------------------------------------------------------------
// bloom_table_writer
//
// Builds and owns the censor Bloom table.
// - Each accepted hash pair sets two table bits.
// - A chunked clear sweep zeroes the table over TABLE_BITS/CLR_CHUNK cycles,
//   so the table can be reloaded at run time.
// - Fill and insert statistics are kept for software readback.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   ins_valid     insert request (held by requester until accepted)
//   ins_ready     insert accepted on an edge where ins_valid & ins_ready
//   hash1, hash2  bit indices to set
//   clr_req       start a clear sweep (pulse or level; ignored while sweeping)
//   clr_busy      clear sweep in progress
//   table_valid   table stable and usable by the lookup stage
//   bloom_table   registered table contents
//   fill_count    number of bits currently set
//   insert_count  accepted inserts, saturating at 16'hFFFF
//
// Optional feature macro BLOOM_DUP_DETECT_EN adds:
//   dup_hit       one-cycle pulse after an insert whose two bits were already set
//   dup_count     number of such inserts, saturating, cleared with the table
// -----------------------------------------------------------------------------
module bloom_table_writer #(
    parameter int TABLE_BITS = 1024,
    parameter int HASH_W     = 10,
    parameter int CLR_CHUNK  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [HASH_W-1:0]     hash1,
    input  logic [HASH_W-1:0]     hash2,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  table_valid,
    output logic [TABLE_BITS-1:0] bloom_table,
    output logic [HASH_W:0]       fill_count,
    output logic [15:0]           insert_count
`ifdef BLOOM_DUP_DETECT_EN
    ,
    output logic                  dup_hit,
    output logic [15:0]           dup_count
`endif
);

    localparam int N_CHUNKS = TABLE_BITS / CLR_CHUNK;
    localparam int PTR_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        ptr_reg, ptr_next;
    logic [TABLE_BITS-1:0]   table_reg, table_next;
    logic [TABLE_BITS-1:0]   set_mask, clr_mask;
    logic [HASH_W:0]         fill_reg, fill_next;
    logic [15:0]             ins_cnt_reg, ins_cnt_next;
    logic                    start_clr;
    logic                    accept;
    logic                    new1, new2;
    logic [1:0]              added;
    logic [HASH_W:0]         fill_sum;

    // ---------------------------------------------------------------
    // FSM next-state and outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        ins_ready   = 1'b0;
        clr_busy    = 1'b0;
        table_valid = 1'b0;
        start_clr   = 1'b0;
        case (state_reg)
            IDLE: begin
                table_valid = 1'b1;
                // Clear wins over a simultaneous insert; the requester retries.
                ins_ready   = !clr_req;
                if (clr_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                    start_clr  = 1'b1;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == PTR_W'(N_CHUNKS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = ins_valid && ins_ready;

    // Only bits that flip 0->1 add to the fill count; an identical pair counts once.
    assign new1  = !table_reg[hash1];
    assign new2  = !table_reg[hash2] && (hash1 != hash2);
    assign added = 2'(new1) + 2'(new2);

    always_comb begin
        set_mask = '0;
        if (accept) begin
            set_mask = (TABLE_BITS'(1) << hash1) | (TABLE_BITS'(1) << hash2);
        end
    end

    // One clear-enable per chunk, selected by the sweep pointer.
    generate
        for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_clr_chunk
            assign clr_mask[gi*CLR_CHUNK +: CLR_CHUNK] =
                {CLR_CHUNK{(state_reg == CLEAR) && (ptr_reg == PTR_W'(gi))}};
        end
    endgenerate

    assign table_next = (table_reg & ~clr_mask) | set_mask;
    assign fill_sum   = fill_reg + (HASH_W+1)'(added);

    always_comb begin
        fill_next    = fill_reg;
        ins_cnt_next = ins_cnt_reg;
        if (start_clr) begin
            fill_next    = '0;
            ins_cnt_next = '0;
        end else if (accept) begin
            fill_next = (fill_sum > (HASH_W+1)'(TABLE_BITS)) ?
                        (HASH_W+1)'(TABLE_BITS) : fill_sum;
            if (ins_cnt_reg != 16'hFFFF) begin
                ins_cnt_next = ins_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            table_reg   <= '0;
            fill_reg    <= '0;
            ins_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            table_reg   <= table_next;
            fill_reg    <= fill_next;
            ins_cnt_reg <= ins_cnt_next;
        end
    end

    assign bloom_table  = table_reg;
    assign fill_count   = fill_reg;
    assign insert_count = ins_cnt_reg;

`ifdef BLOOM_DUP_DETECT_EN
    logic        dup_hit_reg;
    logic [15:0] dup_cnt_reg;
    logic        dup_event;

    // Both bits already present before this insert: word probably seen before.
    assign dup_event = accept && table_reg[hash1] && table_reg[hash2];

    always_ff @(posedge clk) begin
        if (rst) begin
            dup_hit_reg <= 1'b0;
            dup_cnt_reg <= '0;
        end else begin
            dup_hit_reg <= dup_event;
            if (start_clr) begin
                dup_cnt_reg <= '0;
            end else if (dup_event && (dup_cnt_reg != 16'hFFFF)) begin
                dup_cnt_reg <= dup_cnt_reg + 16'd1;
            end
        end
    end

    assign dup_hit   = dup_hit_reg;
    assign dup_count = dup_cnt_reg;
`endif

endmodule

// File: tb/tb_bloom_table_writer.sv
// -----------------------------------------------------------------------------
// tb_bloom_table_writer
//
// Directed-vector bench for bloom_table_writer at default parameters.
// Inputs are driven 1 time unit after the rising edge, outputs sampled there.
// -----------------------------------------------------------------------------
module tb_bloom_table_writer;

    localparam int TABLE_BITS = 1024;
    localparam int HASH_W     = 10;
    localparam int CLR_CHUNK  = 64;

    logic                  clk;
    logic                  rst;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [HASH_W-1:0]     hash1;
    logic [HASH_W-1:0]     hash2;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  table_valid;
    logic [TABLE_BITS-1:0] bloom_table;
    logic [HASH_W:0]       fill_count;
    logic [15:0]           insert_count;
`ifdef BLOOM_DUP_DETECT_EN
    logic                  dup_hit;
    logic [15:0]           dup_count;
`endif

    int checks;
    int failures;

    bloom_table_writer #(
        .TABLE_BITS (TABLE_BITS),
        .HASH_W     (HASH_W),
        .CLR_CHUNK  (CLR_CHUNK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .hash1        (hash1),
        .hash2        (hash2),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .table_valid  (table_valid),
        .bloom_table  (bloom_table),
        .fill_count   (fill_count),
        .insert_count (insert_count)
`ifdef BLOOM_DUP_DETECT_EN
        ,
        .dup_hit      (dup_hit),
        .dup_count    (dup_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (clr_busy && n < 40) begin
            if (ins_ready !== 1'b0 || table_valid !== 1'b0) begin
                chk({tag, "_ready_valid_low"}, {30'd0, ins_ready, table_valid}, 32'd0);
            end
            // A second request mid-sweep must not restart it.
            clr_req = (n == 8);
            step();
            n++;
        end
        clr_req = 1'b0;
        chk({tag, "_cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        int ready_cycles;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        ins_valid = 1'b0;
        hash1     = '0;
        hash2     = '0;
        clr_req   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_fill",   32'(fill_count), 0);
        chk("rst_ins",    32'(insert_count), 0);
        chk("rst_busy",   32'(clr_busy), 0);
        chk("rst_valid",  32'(table_valid), 1);
        chk("rst_ready",  32'(ins_ready), 1);
        chk("rst_ones",   32'($countones(bloom_table)), 0);

        // 1. Insert (3,700)
        ins_valid = 1'b1; hash1 = 10'd3; hash2 = 10'd700;
        step();
        ins_valid = 1'b0;
        chk("t1_bit3",   32'(bloom_table[3]), 1);
        chk("t1_bit700", 32'(bloom_table[700]), 1);
        chk("t1_fill",   32'(fill_count), 2);
        chk("t1_ins",    32'(insert_count), 1);

        // 2. Identical pair counts once; repeat pair adds no fill
        ins_valid = 1'b1; hash1 = 10'd5; hash2 = 10'd5;
        step();
        chk("t2_fill_55", 32'(fill_count), 3);
        chk("t2_bit5",    32'(bloom_table[5]), 1);
`ifdef BLOOM_DUP_DETECT_EN
        chk("t2_dup_new", 32'(dup_hit), 0);
`endif
        hash1 = 10'd3; hash2 = 10'd700;
        step();
        ins_valid = 1'b0;
        chk("t2_fill_rep", 32'(fill_count), 3);
        chk("t2_ins_rep",  32'(insert_count), 3);
`ifdef BLOOM_DUP_DETECT_EN
        chk("t2_dup_hit",  32'(dup_hit), 1);
        chk("t2_dup_cnt",  32'(dup_count), 1);
`endif
        step();
`ifdef BLOOM_DUP_DETECT_EN
        chk("t2_dup_pulse", 32'(dup_hit), 0);
`endif

        // 3. Add 20 distinct bits, then clear
        for (int i = 10; i < 20; i++) begin
            ins_valid = 1'b1;
            hash1 = HASH_W'(i);
            hash2 = HASH_W'(i + 100);
            step();
        end
        ins_valid = 1'b0;
        chk("t3_fill_pre", 32'(fill_count), 23);
        chk("t3_ones_pre", 32'($countones(bloom_table)), 23);
        clr_req = 1'b1;
        #1;
        chk("t3_ready_on_req", 32'(ins_ready), 0);
        step();
        clr_req = 1'b0;
        chk("t3_busy",       32'(clr_busy), 1);
        chk("t3_fill_start", 32'(fill_count), 0);
        wait_clear("t3_clear");
        chk("t3_ones_post",  32'($countones(bloom_table)), 0);
        chk("t3_fill_post",  32'(fill_count), 0);
        chk("t3_valid_post", 32'(table_valid), 1);
        chk("t3_ready_post", 32'(ins_ready), 1);

        // 4. Clear wins over a simultaneous insert; held insert retries after
        ins_valid = 1'b1; hash1 = 10'd9; hash2 = 10'd10;
        clr_req   = 1'b1;
        step();
        clr_req = 1'b0;
        chk("t4_bit9_blocked", 32'(bloom_table[9]), 0);
        chk("t4_ins_blocked",  32'(insert_count), 0);
        wait_clear("t4_clear");
        chk("t4_bit9_wait", 32'(bloom_table[9]), 0);
        step();
        ins_valid = 1'b0;
        chk("t4_bit9",  32'(bloom_table[9]), 1);
        chk("t4_bit10", 32'(bloom_table[10]), 1);
        chk("t4_fill",  32'(fill_count), 2);
        chk("t4_ins",   32'(insert_count), 1);

        // 5. Reset on clear cycle 5 abandons the sweep
        ins_valid = 1'b1; hash1 = 10'd1000; hash2 = 10'd600;
        step();
        ins_valid = 1'b0;
        clr_req   = 1'b1;
        step();
        clr_req = 1'b0;
        step(); step(); step(); step();
        chk("t5_busy_mid",   32'(clr_busy), 1);
        chk("t5_bit1000_mid", 32'(bloom_table[1000]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy_rst",  32'(clr_busy), 0);
        chk("t5_ones_rst",  32'($countones(bloom_table)), 0);
        chk("t5_ready_rst", 32'(ins_ready), 1);
        chk("t5_fill_rst",  32'(fill_count), 0);

        // 6. 65536+3 back-to-back inserts: saturation and full table
        ready_cycles = 0;
        ins_valid    = 1'b1;
        for (int i = 0; i < 65539; i++) begin
            hash1 = HASH_W'(i % TABLE_BITS);
            hash2 = HASH_W'((i + 1) % TABLE_BITS);
            if (ins_ready) ready_cycles++;
            step();
            if (i == 65533) chk("t6_ins_fffe", 32'(insert_count), 32'hFFFE);
        end
        ins_valid = 1'b0;
        chk("t6_ready_cycles", 32'(ready_cycles), 65539);
        chk("t6_ins_sat",      32'(insert_count), 32'hFFFF);
        chk("t6_fill_full",    32'(fill_count), TABLE_BITS);
        chk("t6_ones_full",    32'($countones(bloom_table)), TABLE_BITS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
